// File: rtl/axis_fifo_sync.sv
// Single-clock AXI-stream FIFO with first-word fall-through and tlast storage.
// Define AXIS_FIFO_SYNC_PKT_MODE_EN to hold output until a whole packet is stored.
module axis_fifo_sync #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned FIFO_DEPTH = 16,
   localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [AW:0]           fifo_count
);

   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic [DATA_WIDTH:0] rd_entry;
   logic                empty, full, wr_en, rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Gated by rst_n so the producer sees ready low for the whole reset window.
   assign s_axis_tready = ~full & rst_n;
   assign wr_en         = s_axis_tvalid & s_axis_tready;
   assign rd_en         = m_axis_tvalid & m_axis_tready;

   assign rd_entry     = mem_q[rd_ptr_q[AW-1:0]];
   assign m_axis_tdata = rd_entry[DATA_WIDTH:1];
   assign m_axis_tlast = rd_entry[0];
   assign fifo_count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_en && !rd_en) begin
         count_d = count_q + PtrOne;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - PtrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tlast};
   end

`ifdef AXIS_FIFO_SYNC_PKT_MODE_EN
   logic [AW:0] pkt_cnt_q, pkt_cnt_d;
   logic        cut_thru_q, cut_thru_d;
   logic        wr_last, rd_last;

   assign wr_last = wr_en & s_axis_tlast;
   assign rd_last = rd_en & m_axis_tlast;

   // A full FIFO with no complete packet must drain in cut-through or it deadlocks.
   assign m_axis_tvalid = ~empty & ((pkt_cnt_q != '0) | full | cut_thru_q);

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      cut_thru_d = cut_thru_q;
      if (wr_last && !rd_last) begin
         pkt_cnt_d = pkt_cnt_q + PtrOne;
      end else if (!wr_last && rd_last) begin
         pkt_cnt_d = pkt_cnt_q - PtrOne;
      end
      if (rd_last) begin
         cut_thru_d = 1'b0;
      end else if (full && (pkt_cnt_q == '0)) begin
         cut_thru_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_q  <= '0;
         cut_thru_q <= 1'b0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         cut_thru_q <= cut_thru_d;
      end
   end
`else
   assign m_axis_tvalid = ~empty;
`endif

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Directed bench for axis_fifo_sync: fill/drain, streaming scoreboard, reset, packet mode.
module tb_axis_fifo_sync;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [AW:0]   count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axis_fifo_sync #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis_tvalid(s_valid),
      .s_axis_tready(s_ready),
      .s_axis_tdata (s_data),
      .s_axis_tlast (s_last),
      .m_axis_tvalid(m_valid),
      .m_axis_tready(m_ready),
      .m_axis_tdata (m_data),
      .m_axis_tlast (m_last),
      .fifo_count   (count)
   );

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_valid); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_tready_low got=%b exp=0", s_ready); end
      rst_n = 1'b1;
      #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_tready_rel got=%b exp=1", s_ready); end
   endtask

   task automatic test_fill();
      m_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_tready[%0d] got=%b exp=1", i, s_ready); end
`ifdef AXIS_FIFO_SYNC_PKT_MODE_EN
         if (i == 2) begin
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fill_pkt_hold got=%b exp=0", m_valid); end
         end
`else
         if (i == 2) begin
            total++; if (m_valid !== 1'b1 || m_data !== 32'd1) begin
               bad++; $display("FAIL fill_fwft got=%b/%0h exp=1/1", m_valid, m_data);
            end
         end
`endif
         s_valid = 1'b1; s_data = DW'(i); s_last = (i == DEPTH);
         @(negedge clk);
      end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_tready got=%b exp=0", s_ready); end
      total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", count); end
      total++; if (m_valid !== 1'b1 || m_data !== 32'd1) begin
         bad++; $display("FAIL full_head got=%b/%0h exp=1/1", m_valid, m_data);
      end
      // Attempted write while full must be dropped.
      s_data = 32'h99; s_last = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      total++; if (count !== 5'd16 || m_data !== 32'd1) begin
         bad++; $display("FAIL full_nowrite got=%0d/%0h exp=16/1", count, m_data);
      end
   endtask

   task automatic test_drain();
      m_ready = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         total++;
         if (m_valid !== 1'b1 || m_data !== DW'(i) || m_last !== (i == DEPTH) || count !== 5'(17 - i)) begin
            bad++;
            $display("FAIL drain[%0d] got v=%b d=%0h l=%b c=%0d exp v=1 d=%0h l=%b c=%0d",
                     i, m_valid, m_data, m_last, count, i, (i == DEPTH), 17 - i);
         end
         @(negedge clk);
      end
      total++; if (m_valid !== 1'b0 || count !== 5'd0) begin
         bad++; $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", m_valid, count);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         s_valid = 1'b1; s_data = DW'(32'h50 + i); s_last = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b0;
      total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_count got=%0d exp=5", count); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (count !== 5'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++; $display("FAIL mid_reset got c=%0d v=%b r=%b exp c=0 v=0 r=1", count, m_valid, s_ready);
      end
   endtask

   task automatic test_stream();
      logic [DW:0]   q[$];
      int            sent = 0;
      int            cycles = 0;
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic          prev_last = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
         s_valid = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
         s_data  = 32'hA000_0000 + sent;
         s_last  = ((sent + 1) % 8 == 0);
         m_ready = $urandom_range(0, 1) == 1;
         #1;
         if (prev_stall) begin
            total++; if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
               bad++; $display("FAIL stream_hold got v=%b d=%0h exp v=1 d=%0h", m_valid, m_data, prev_data);
            end
         end
         total++; if (int'(count) !== q.size()) begin
            bad++; $display("FAIL stream_count got=%0d exp=%0d", count, q.size());
         end
         if (m_valid && m_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL stream_dup got d=%0h exp=none", m_data);
            end else begin
               if ({m_data, m_last} !== q[0]) begin
                  bad++; $display("FAIL stream_data got=%0h/%b exp=%0h/%b", m_data, m_last,
                                  q[0][DW:1], q[0][0]);
               end
               void'(q.pop_front());
            end
         end
         if (s_valid && s_ready) begin
            q.push_back({s_data, s_last});
            sent++;
         end
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         cycles++;
         @(negedge clk);
      end
      s_valid = 1'b0; m_ready = 1'b0;
      total++; if (sent != 1000 || q.size() != 0) begin
         bad++; $display("FAIL stream_done got sent=%0d left=%0d exp sent=1000 left=0", sent, q.size());
      end
   endtask

`ifdef AXIS_FIFO_SYNC_PKT_MODE_EN
   task automatic test_pkt_hold();
      m_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         s_valid = 1'b1; s_data = DW'(32'h70 + i); s_last = (i == 3);
         @(negedge clk);
         total++; if (m_valid !== (i == 3)) begin
            bad++; $display("FAIL pkt_hold[%0d] got=%b exp=%b", i, m_valid, (i == 3));
         end
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         total++; if (m_valid !== 1'b1 || m_data !== DW'(32'h70 + i) || m_last !== (i == 3)) begin
            bad++; $display("FAIL pkt_out[%0d] got v=%b d=%0h l=%b", i, m_valid, m_data, m_last);
         end
         @(negedge clk);
      end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL pkt_empty got=%b exp=0", m_valid); end
      m_ready = 1'b0;
   endtask

   task automatic test_cut_thru();
      int idx_in = 0;
      int idx_out = 0;
      int cycles = 0;
      m_ready = 1'b1;
      while (idx_out < 20 && cycles < 500) begin
         s_valid = (idx_in < 20);
         s_data  = DW'(32'h100 + idx_in + 1);
         s_last  = (idx_in == 19);
         #1;
         if (m_valid && m_ready) begin
            if (idx_out == 0) begin
               total++; if (count !== 5'd16) begin bad++; $display("FAIL cut_start got=%0d exp=16", count); end
            end
            total++; if (m_data !== DW'(32'h100 + idx_out + 1) || m_last !== (idx_out == 19)) begin
               bad++; $display("FAIL cut_data[%0d] got=%0h/%b exp=%0h/%b", idx_out, m_data, m_last,
                               32'h100 + idx_out + 1, (idx_out == 19));
            end
            idx_out++;
         end
         if (s_valid && s_ready) idx_in++;
         cycles++;
         @(negedge clk);
      end
      s_valid = 1'b0; m_ready = 1'b0;
      total++; if (idx_out != 20 || m_valid !== 1'b0 || count !== 5'd0) begin
         bad++; $display("FAIL cut_done got out=%0d v=%b c=%0d exp out=20 v=0 c=0", idx_out, m_valid, count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_reset_mid();
      test_stream();
`ifdef AXIS_FIFO_SYNC_PKT_MODE_EN
      test_pkt_hold();
      test_cut_thru();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
